bsg_manycore_vcache_wh_to_mem: RTL and testbench
================================================

Name: bsg_manycore_vcache_wh_to_mem

Overview:
- Memory-side endpoint of the vcache DMA wormhole network. Sits at the east or west edge of a vcache row, downstream of the edge vcache tile's wormhole P/E/W links.
- Receives vcache DMA read and write packets, converts them into per-beat memory commands on a simple valid/ready memory port, and returns read fills as wormhole packets.
- Serves one packet at a time, in arrival order.

Parameters:
- wh_flit_width_p, 32: flit width; must equal dma_data_width_p.
- wh_cord_width_p, 7: wormhole cord field width.
- wh_len_width_p, 4: wormhole len field width.
- wh_cid_width_p, 2: concentrator id width.
- dma_addr_width_p, 28: byte address width.
- dma_data_width_p, 32: memory beat width.
- dma_burst_len_p, 8: beats per cache block; must be ≤ 2^wh_len_width_p-1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- wh_link_sif_i  in  bsg_ready_and_link_sif_width(wh_flit_width_p)  incoming flits, plus ready_and for outgoing flits.
- wh_link_sif_o  out  same  outgoing flits, plus ready_and for incoming flits.
- my_wh_cord_i  in  wh_cord_width_p  this endpoint's cord; used as src cord of responses.
- mem_v_o  out  1  memory command valid.
- mem_w_o  out  1  1=write, 0=read.
- mem_addr_o  out  dma_addr_width_p  beat byte address.
- mem_data_o  out  dma_data_width_p  write data.
- mem_ready_i  in  1  command accepted when mem_v_o & mem_ready_i.
- mem_data_v_i  in  1  read data valid.
- mem_data_i  in  dma_data_width_p  read data.
- mem_data_yumi_o  out  1  read data consumed.
- err_o  out  1  sticky length error (see Optional Feature).

Behaviour:
- Header flit fields, LSB first: cord, len, cid, src_cord, src_cid, write_not_read; remaining bits are zero.
- Second flit carries the address in bits [dma_addr_width_p-1:0].
- Write packet: len = 1+burst_len; burst_len data flits follow the address flit.
- Read packet: len = 1.
- Read response: header with cord=src_cord, cid=src_cid, len=burst_len, src_cord=my_wh_cord_i, write_not_read=0; then burst_len data flits.
- Reset values: state=RECV_HDR; all valid/yumi outputs 0; counters 0; err_o 0; in-link ready 0 for the cycle after reset deassertion, then 1 in RECV_HDR.
- FSM:
  - RECV_HDR: ready=1. On accept, latch the header and go to RECV_ADDR.
  - RECV_ADDR: ready=1. On accept, latch addr and clear beat counters. Go to WRITE if write_not_read, else SEND_HDR.
  - WRITE: mem_v_o = incoming flit valid; in-link ready = mem_ready_i (flit passes straight through). Each accepted beat increments wcnt. After beat burst_len-1, go to RECV_HDR.
  - SEND_HDR: out valid=1 with the response header. On ready, go to READ.
  - READ: two independent counters.
    - Issue: mem_v_o=1, mem_w_o=0 while icnt<burst_len; icnt increments on mem_ready_i.
    - Return: out flit = mem_data_i, out valid = mem_data_v_i, mem_data_yumi_o = mem_data_v_i & out ready; rcnt increments on yumi.
    - Leave for RECV_HDR when rcnt reaches burst_len on yumi.
- Beat address is addr + cnt*(dma_data_width_p/8), truncated to dma_addr_width_p (wraps at 2^dma_addr_width_p). cnt is wcnt in WRITE and icnt in READ.
- Counters are clog2(burst_len+1) wide and never exceed burst_len.
- No write acknowledgement is ever sent.
- Memory must return read data in order. No flit is accepted outside RECV_HDR, RECV_ADDR or WRITE.
- Issue and return in the same cycle are both legal; each counter advances independently.
- Reset mid-packet aborts immediately to RECV_HDR. Partial memory traffic is not undone.

Optional Feature:
- Macro BSG_MANYCORE_VCACHE_WH_TO_MEM_LEN_CHECK_EN.
- Defined: the header len is compared against the expected value (write 1+burst_len, read 1).
  - On mismatch: set sticky err_o, enter DRAIN, and accept len further flits with no memory traffic and no response. Then return to RECV_HDR.
- Undefined: len is ignored, err_o is tied 0, and there is no DRAIN state.

Decomposition:
- Shared package (bsg_manycore_pkg): wh header struct macro (cord, len, cid, src_cord, src_cid, write_not_read); state enum.
- Sub-module bsg_manycore_vcache_wh_to_mem_addr_gen: base latch, beat counter, and address adder. Instantiated twice, for the write path and the read-issue path.

Test Plan:
- Write: addr 0x100, data 1..8, mem_ready_i=1 → 8 writes at 0x100,0x104..0x11C with data 1..8; no outgoing flits.
- Read: addr 0x2000, src_cord=3, src_cid=2; memory returns A0..A7 → response header cord=3, cid=2, len=8, then A0..A7 in order.
- Backpressure: out ready toggles 1/0 and mem_ready_i random during a read → exactly 8 commands issued and 8 yumis; no data dropped or duplicated.
- Wrap: write at addr 2^28-8 → beats at 0xFFFFFF8, 0xFFFFFFC, 0x0000000..0x0000014.
- Reset asserted after 3 write beats → mem_v_o=0 at once; a following read packet completes normally.
- With macro: write header len=5 → err_o=1, 5 flits drained, zero memory commands; the next valid read succeeds with err_o still 1.

Source files
------------

// File: rtl/bsg_manycore_vcache_wh_to_mem_pkg.sv
// Shared types for the vcache wormhole-to-memory endpoint.
//   wh_hdr_s : wormhole header flit, fields LSB first: cord, len, cid,
//              src_cord, src_cid, write_not_read; upper bits zero.
//   state_e  : endpoint FSM states (DRAIN only exists when
//              BSG_MANYCORE_VCACHE_WH_TO_MEM_LEN_CHECK_EN is defined).
package bsg_manycore_vcache_wh_to_mem_pkg;

    localparam int unsigned WH_FLIT_WIDTH = 32;
    localparam int unsigned WH_CORD_WIDTH = 7;
    localparam int unsigned WH_LEN_WIDTH  = 4;
    localparam int unsigned WH_CID_WIDTH  = 2;
    localparam int unsigned WH_HDR_USED   = 2*WH_CORD_WIDTH + WH_LEN_WIDTH + 2*WH_CID_WIDTH + 1;
    localparam int unsigned WH_HDR_PAD    = WH_FLIT_WIDTH - WH_HDR_USED;

    typedef struct packed {
        logic [WH_HDR_PAD-1:0]    pad;
        logic                     write_not_read;
        logic [WH_CID_WIDTH-1:0]  src_cid;
        logic [WH_CORD_WIDTH-1:0] src_cord;
        logic [WH_CID_WIDTH-1:0]  cid;
        logic [WH_LEN_WIDTH-1:0]  len;
        logic [WH_CORD_WIDTH-1:0] cord;
    } wh_hdr_s;

    typedef enum logic [2:0] {
        S_RECV_HDR,
        S_RECV_ADDR,
        S_WRITE,
        S_SEND_HDR,
        S_READ
`ifdef BSG_MANYCORE_VCACHE_WH_TO_MEM_LEN_CHECK_EN
        , S_DRAIN
`endif
    } state_e;

endpackage

// File: rtl/bsg_manycore_vcache_wh_to_mem_if.sv
// Wormhole ready/valid link pair seen by the memory endpoint.
//   in_*  : flits toward the endpoint (in_ready_and driven by the endpoint)
//   out_* : flits from the endpoint (out_ready_and driven by the network)
// slave modport is the endpoint side, master the network side.
interface bsg_manycore_vcache_wh_to_mem_if #(
    parameter int unsigned flit_width_p = 32
);
    logic                    in_v;
    logic [flit_width_p-1:0] in_data;
    logic                    in_ready_and;
    logic                    out_v;
    logic [flit_width_p-1:0] out_data;
    logic                    out_ready_and;

    modport slave (
        input  in_v, in_data, out_ready_and,
        output in_ready_and, out_v, out_data
    );

    modport master (
        output in_v, in_data, out_ready_and,
        input  in_ready_and, out_v, out_data
    );
endinterface

// File: rtl/bsg_manycore_vcache_wh_to_mem_addr_gen.sv
// Beat address generator: latches a base address, counts beats and
// produces base + cnt*stride (wrapping at 2^addr_width_p).
//   load_i : latch base_i and clear the beat counter
//   inc_i  : advance the counter (saturates at burst_len_p)
//   cnt_o  : current beat count
//   addr_o : current beat byte address
module bsg_manycore_vcache_wh_to_mem_addr_gen #(
    parameter int unsigned addr_width_p = 28,
    parameter int unsigned burst_len_p  = 8,
    parameter int unsigned stride_p     = 4,
    localparam int unsigned cnt_width_lp = $clog2(burst_len_p+1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic [addr_width_p-1:0] base_i,
    input  logic                    inc_i,
    output logic [cnt_width_lp-1:0] cnt_o,
    output logic [addr_width_p-1:0] addr_o
);
    localparam logic [cnt_width_lp-1:0] burst_lp = cnt_width_lp'(burst_len_p);

    logic [addr_width_p-1:0] base_q;
    logic [cnt_width_lp-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            base_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            base_q <= base_i;
            cnt_q  <= '0;
        end else if (inc_i && (cnt_q < burst_lp)) begin
            cnt_q <= cnt_q + cnt_width_lp'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign addr_o = base_q + addr_width_p'(cnt_q) * addr_width_p'(stride_p);
endmodule

// File: rtl/bsg_manycore_vcache_wh_to_mem.sv
// Memory-side endpoint of the vcache DMA wormhole network. Takes one
// read/write packet at a time, issues per-beat memory commands and
// returns read fills as wormhole packets.
//   clk_i, reset_i    : clock, asynchronous active-high reset
//   wh_link_sif       : wormhole in/out flit link (slave side)
//   my_wh_cord_i      : this endpoint's cord (src cord of responses)
//   mem_v_o/mem_w_o/mem_addr_o/mem_data_o/mem_ready_i : memory command
//   mem_data_v_i/mem_data_i/mem_data_yumi_o           : memory read data
//   err_o             : sticky header length error
// Optional: define BSG_MANYCORE_VCACHE_WH_TO_MEM_LEN_CHECK_EN to check the
// header len field and drain malformed packets; otherwise err_o is 0.
module bsg_manycore_vcache_wh_to_mem
    import bsg_manycore_vcache_wh_to_mem_pkg::*;
#(
    parameter int unsigned wh_flit_width_p  = 32,
    parameter int unsigned wh_cord_width_p  = 7,
    parameter int unsigned wh_len_width_p   = 4,
    parameter int unsigned wh_cid_width_p   = 2,
    parameter int unsigned dma_addr_width_p = 28,
    parameter int unsigned dma_data_width_p = 32,
    parameter int unsigned dma_burst_len_p  = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bsg_manycore_vcache_wh_to_mem_if.slave wh_link_sif,
    input  logic [wh_cord_width_p-1:0]  my_wh_cord_i,
    output logic                        mem_v_o,
    output logic                        mem_w_o,
    output logic [dma_addr_width_p-1:0] mem_addr_o,
    output logic [dma_data_width_p-1:0] mem_data_o,
    input  logic                        mem_ready_i,
    input  logic                        mem_data_v_i,
    input  logic [dma_data_width_p-1:0] mem_data_i,
    output logic                        mem_data_yumi_o,
    output logic                        err_o
);
    localparam int unsigned cnt_width_lp = $clog2(dma_burst_len_p+1);
    localparam logic [cnt_width_lp-1:0] burst_lp = cnt_width_lp'(dma_burst_len_p);
    localparam logic [cnt_width_lp-1:0] last_lp  = cnt_width_lp'(dma_burst_len_p-1);

    state_e  state_q, state_d;
    wh_hdr_s hdr_q, hdr_d;
    wh_hdr_s in_hdr, resp_hdr;
    logic    ready_en_q;
    logic [cnt_width_lp-1:0] rcnt_q, rcnt_d;

    logic                        addr_load, winc, iinc;
    logic [cnt_width_lp-1:0]     wcnt, icnt;
    logic [dma_addr_width_p-1:0] waddr, raddr;
    logic [wh_cid_width_p-1:0]   resp_cid;

    assign in_hdr   = wh_hdr_s'(wh_link_sif.in_data);
    assign resp_cid = hdr_q.src_cid;

    always_comb begin
        resp_hdr          = '0;
        resp_hdr.cord     = hdr_q.src_cord;
        resp_hdr.len      = wh_len_width_p'(dma_burst_len_p);
        resp_hdr.cid      = resp_cid;
        resp_hdr.src_cord = my_wh_cord_i;
    end

    bsg_manycore_vcache_wh_to_mem_addr_gen #(
        .addr_width_p(dma_addr_width_p),
        .burst_len_p (dma_burst_len_p),
        .stride_p    (dma_data_width_p/8)
    ) wr_gen (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (addr_load),
        .base_i (wh_link_sif.in_data[dma_addr_width_p-1:0]),
        .inc_i  (winc),
        .cnt_o  (wcnt),
        .addr_o (waddr)
    );

    bsg_manycore_vcache_wh_to_mem_addr_gen #(
        .addr_width_p(dma_addr_width_p),
        .burst_len_p (dma_burst_len_p),
        .stride_p    (dma_data_width_p/8)
    ) rd_gen (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (addr_load),
        .base_i (wh_link_sif.in_data[dma_addr_width_p-1:0]),
        .inc_i  (iinc),
        .cnt_o  (icnt),
        .addr_o (raddr)
    );

`ifdef BSG_MANYCORE_VCACHE_WH_TO_MEM_LEN_CHECK_EN
    localparam logic [wh_len_width_p-1:0] wr_len_lp = wh_len_width_p'(1 + dma_burst_len_p);
    localparam logic [wh_len_width_p-1:0] rd_len_lp = wh_len_width_p'(1);

    logic                      err_q, err_d;
    logic [wh_len_width_p-1:0] dcnt_q, dcnt_d;
    logic [wh_len_width_p-1:0] exp_len;

    assign exp_len = in_hdr.write_not_read ? wr_len_lp : rd_len_lp;
    assign err_o   = err_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q  <= 1'b0;
            dcnt_q <= '0;
        end else begin
            err_q  <= err_d;
            dcnt_q <= dcnt_d;
        end
    end
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d                  = state_q;
        hdr_d                    = hdr_q;
        rcnt_d                   = rcnt_q;
        addr_load                = 1'b0;
        winc                     = 1'b0;
        iinc                     = 1'b0;
        wh_link_sif.in_ready_and = 1'b0;
        wh_link_sif.out_v        = 1'b0;
        wh_link_sif.out_data     = '0;
        mem_v_o                  = 1'b0;
        mem_w_o                  = 1'b0;
        mem_addr_o               = waddr;
        mem_data_o               = wh_link_sif.in_data;
        mem_data_yumi_o          = 1'b0;
`ifdef BSG_MANYCORE_VCACHE_WH_TO_MEM_LEN_CHECK_EN
        err_d                    = err_q;
        dcnt_d                   = dcnt_q;
`endif
        case (state_q)
            S_RECV_HDR: begin
                // ready is held low for the first cycle out of reset
                wh_link_sif.in_ready_and = ready_en_q;
                if (wh_link_sif.in_v && ready_en_q) begin
                    hdr_d   = in_hdr;
                    state_d = S_RECV_ADDR;
`ifdef BSG_MANYCORE_VCACHE_WH_TO_MEM_LEN_CHECK_EN
                    if (in_hdr.len != exp_len) begin
                        err_d   = 1'b1;
                        dcnt_d  = in_hdr.len;
                        state_d = (in_hdr.len == '0) ? S_RECV_HDR : S_DRAIN;
                    end
`endif
                end
            end
            S_RECV_ADDR: begin
                wh_link_sif.in_ready_and = 1'b1;
                if (wh_link_sif.in_v) begin
                    addr_load = 1'b1;
                    rcnt_d    = '0;
                    state_d   = hdr_q.write_not_read ? S_WRITE : S_SEND_HDR;
                end
            end
            S_WRITE: begin
                // flit passes straight through to the memory port
                mem_v_o                  = wh_link_sif.in_v;
                mem_w_o                  = 1'b1;
                mem_addr_o               = waddr;
                wh_link_sif.in_ready_and = mem_ready_i;
                if (wh_link_sif.in_v && mem_ready_i) begin
                    winc = 1'b1;
                    if (wcnt == last_lp) state_d = S_RECV_HDR;
                end
            end
            S_SEND_HDR: begin
                wh_link_sif.out_v    = 1'b1;
                wh_link_sif.out_data = resp_hdr;
                if (wh_link_sif.out_ready_and) state_d = S_READ;
            end
            S_READ: begin
                // issue and return run on independent counters
                mem_v_o              = (icnt < burst_lp);
                mem_addr_o           = raddr;
                iinc                 = mem_v_o && mem_ready_i;
                wh_link_sif.out_v    = mem_data_v_i;
                wh_link_sif.out_data = mem_data_i;
                mem_data_yumi_o      = mem_data_v_i && wh_link_sif.out_ready_and;
                if (mem_data_yumi_o) begin
                    rcnt_d = rcnt_q + cnt_width_lp'(1);
                    if (rcnt_q == last_lp) state_d = S_RECV_HDR;
                end
            end
`ifdef BSG_MANYCORE_VCACHE_WH_TO_MEM_LEN_CHECK_EN
            S_DRAIN: begin
                wh_link_sif.in_ready_and = 1'b1;
                if (wh_link_sif.in_v) begin
                    dcnt_d = dcnt_q - wh_len_width_p'(1);
                    if (dcnt_q == wh_len_width_p'(1)) state_d = S_RECV_HDR;
                end
            end
`endif
            default: state_d = S_RECV_HDR;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_RECV_HDR;
            hdr_q      <= '0;
            rcnt_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            rcnt_q     <= rcnt_d;
            ready_en_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bsg_manycore_vcache_wh_to_mem.sv
module tb_bsg_manycore_vcache_wh_to_mem;
    localparam int unsigned BURST = 8;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [6:0]  my_cord = 7'h15;
    logic        mem_v_o, mem_w_o, mem_ready_i, mem_data_v_i, mem_data_yumi_o, err_o;
    logic [27:0] mem_addr_o;
    logic [31:0] mem_data_o, mem_data_i;

    always #5 clk = ~clk;

    bsg_manycore_vcache_wh_to_mem_if #(.flit_width_p(32)) link ();

    bsg_manycore_vcache_wh_to_mem #(
        .wh_flit_width_p (32),
        .wh_cord_width_p (7),
        .wh_len_width_p  (4),
        .wh_cid_width_p  (2),
        .dma_addr_width_p(28),
        .dma_data_width_p(32),
        .dma_burst_len_p (BURST)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .wh_link_sif    (link),
        .my_wh_cord_i   (my_cord),
        .mem_v_o        (mem_v_o),
        .mem_w_o        (mem_w_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_ready_i    (mem_ready_i),
        .mem_data_v_i   (mem_data_v_i),
        .mem_data_i     (mem_data_i),
        .mem_data_yumi_o(mem_data_yumi_o),
        .err_o          (err_o)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: packets become expected command/flit streams; ref_img is
    // the memory contents as seen by applying packets in order.
    logic [31:0] in_q[$];
    logic [60:0] exp_cmd[$];
    logic [31:0] exp_out[$];
    logic [31:0] ref_img[int unsigned];
    // Environment memory, written only by DUT commands.
    logic [31:0] tbmem[int unsigned];
    logic [31:0] rdq[$];

    int unsigned p_in = 100, p_out = 100, p_mem = 100, p_dv = 100;
    int unsigned n_rd_cmd = 0, n_yumi = 0;

    function automatic logic [31:0] init_val(input int unsigned a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic int unsigned beat_addr(input int unsigned base, input int unsigned i);
        return (base + i*4) % (1 << 28);
    endfunction

    function automatic logic [31:0] mk_hdr(input int unsigned cord, len, cid, scord, scid, wnr);
        return 32'(cord + (len << 7) + (cid << 11) + (scord << 13) + (scid << 20) + (wnr << 22));
    endfunction

    task automatic send_write(input int unsigned addr, input logic [31:0] d[BURST]);
        in_q.push_back(mk_hdr(1, 1 + BURST, 0, $urandom_range(127), $urandom_range(3), 1));
        in_q.push_back(32'(addr));
        for (int i = 0; i < BURST; i++) begin
            in_q.push_back(d[i]);
            ref_img[beat_addr(addr, i)] = d[i];
            exp_cmd.push_back({1'b1, 28'(beat_addr(addr, i)), d[i]});
        end
    endtask

    task automatic send_read(input int unsigned addr, input int unsigned scord, input int unsigned scid);
        int unsigned a;
        in_q.push_back(mk_hdr(1, 1, 0, scord, scid, 0));
        in_q.push_back(32'(addr));
        exp_out.push_back(mk_hdr(scord, BURST, scid, my_cord, 0, 0));
        for (int i = 0; i < BURST; i++) begin
            a = beat_addr(addr, i);
            exp_cmd.push_back({1'b0, 28'(a), 32'h0});
            exp_out.push_back(ref_img.exists(a) ? ref_img[a] : init_val(a));
        end
    endtask

    // One clock: drive at negedge, settle, then account for handshakes that
    // complete at the following posedge.
    task automatic step();
        logic [60:0] got;
        int unsigned a;
        @(negedge clk);
        link.in_v          = (in_q.size() > 0) && ($urandom_range(99) < p_in);
        link.in_data       = (in_q.size() > 0) ? in_q[0] : 32'h0;
        link.out_ready_and = $urandom_range(99) < p_out;
        mem_ready_i        = $urandom_range(99) < p_mem;
        mem_data_v_i       = (rdq.size() > 0) && ($urandom_range(99) < p_dv);
        mem_data_i         = (rdq.size() > 0) ? rdq[0] : 32'h0;
        #1;
        if (link.in_v && link.in_ready_and) void'(in_q.pop_front());
        if (mem_v_o && mem_ready_i) begin
            got = {mem_w_o, mem_addr_o, mem_w_o ? mem_data_o : 32'h0};
            check_eq("mem_cmd_pending", 64'(exp_cmd.size() > 0), 64'd1);
            if (exp_cmd.size() > 0) check_eq("mem_cmd", 64'(got), 64'(exp_cmd.pop_front()));
            a = int'(mem_addr_o);
            if (mem_w_o) tbmem[a] = mem_data_o;
            else begin
                n_rd_cmd++;
                rdq.push_back(tbmem.exists(a) ? tbmem[a] : init_val(a));
            end
        end
        if (mem_data_yumi_o) begin
            check_eq("yumi_has_valid", 64'(mem_data_v_i), 64'd1);
            n_yumi++;
            if (rdq.size() > 0) void'(rdq.pop_front());
        end
        if (link.out_v && link.out_ready_and) begin
            check_eq("out_flit_pending", 64'(exp_out.size() > 0), 64'd1);
            if (exp_out.size() > 0) check_eq("out_flit", 64'(link.out_data), 64'(exp_out.pop_front()));
        end
    endtask

    task automatic run_until_idle(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while ((in_q.size() + exp_cmd.size() + exp_out.size() + rdq.size()) > 0 && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 64'(in_q.size() + exp_cmd.size() + exp_out.size() + rdq.size()), 64'd0);
        // a few idle cycles: nothing unexpected may appear
        repeat (3) step();
    endtask

    logic [31:0] d[BURST];
    int unsigned guard;

    initial begin
        reset_i            = 1'b1;
        link.in_v          = 1'b0;
        link.in_data       = '0;
        link.out_ready_and = 1'b0;
        mem_ready_i        = 1'b0;
        mem_data_v_i       = 1'b0;
        mem_data_i         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_v", 64'(mem_v_o), 64'd0);
        check_eq("rst_out_v", 64'(link.out_v), 64'd0);
        check_eq("rst_yumi", 64'(mem_data_yumi_o), 64'd0);
        check_eq("rst_err", 64'(err_o), 64'd0);
        check_eq("rst_in_ready", 64'(link.in_ready_and), 64'd0);
        reset_i = 1'b0;
        #1;
        check_eq("in_ready_first_cycle", 64'(link.in_ready_and), 64'd0);
        @(negedge clk);
        #1;
        check_eq("in_ready_after", 64'(link.in_ready_and), 64'd1);

        // Directed write 0x100, data 1..8
        for (int i = 0; i < BURST; i++) d[i] = 32'(i + 1);
        send_write(32'h100, d);
        run_until_idle("write_0x100_done", 200);

        // Directed read 0x2000, src_cord=3, src_cid=2
        send_read(32'h2000, 3, 2);
        run_until_idle("read_0x2000_done", 200);

        // Read back the 0x100 write
        send_read(32'h100, 5, 1);
        run_until_idle("readback_0x100_done", 200);

        // Backpressure read: out ready and memory ready random
        p_out = 50; p_mem = 50; p_dv = 70;
        n_rd_cmd = 0; n_yumi = 0;
        send_read(32'h2000, 9, 3);
        run_until_idle("bp_read_done", 2000);
        check_eq("bp_rd_cmds", 64'(n_rd_cmd), 64'(BURST));
        check_eq("bp_yumis", 64'(n_yumi), 64'(BURST));
        p_out = 100; p_mem = 100; p_dv = 100;

        // Address wrap at top of the 28-bit space, then read it back
        for (int i = 0; i < BURST; i++) d[i] = $urandom;
        send_write(32'h0FFF_FFF8, d);
        run_until_idle("wrap_write_done", 200);
        send_read(32'h0FFF_FFF8, 1, 0);
        run_until_idle("wrap_read_done", 200);

        // Reset after three write beats
        for (int i = 0; i < BURST; i++) d[i] = $urandom;
        send_write(32'h0080_0000, d);
        guard = 0;
        while (exp_cmd.size() > BURST - 3 && guard < 200) begin
            step();
            guard++;
        end
        check_eq("abort_three_beats", 64'(exp_cmd.size()), 64'(BURST - 3));
        @(posedge clk);
        #1;
        check_eq("abort_mem_v_before", 64'(mem_v_o), 64'd1);
        reset_i = 1'b1;
        #1;
        check_eq("abort_mem_v", 64'(mem_v_o), 64'd0);
        in_q.delete();
        exp_cmd.delete();
        for (int i = 3; i < BURST; i++) ref_img.delete(beat_addr(32'h0080_0000, i));
        @(negedge clk);
        reset_i   = 1'b0;
        link.in_v = 1'b0;
        send_read(32'h0080_0000, 4, 1);
        run_until_idle("post_reset_read_done", 200);

        // Random mix of packets under random backpressure
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(1) == 1) begin
                for (int i = 0; i < BURST; i++) d[i] = $urandom;
                send_write(32'h40000 + $urandom_range(63) * 32, d);
            end else begin
                send_read(32'h40000 + $urandom_range(63) * 32, $urandom_range(127), $urandom_range(3));
            end
        end
        p_in = 60; p_out = 60; p_mem = 60; p_dv = 60;
        run_until_idle("random_mix_done", 20000);
        p_in = 100; p_out = 100; p_mem = 100; p_dv = 100;

`ifdef BSG_MANYCORE_VCACHE_WH_TO_MEM_LEN_CHECK_EN
        check_eq("err_before_bad_len", 64'(err_o), 64'd0);
        in_q.push_back(mk_hdr(1, 5, 0, 2, 0, 1));
        for (int i = 0; i < 5; i++) in_q.push_back($urandom);
        run_until_idle("bad_len_drained", 200);
        check_eq("err_set", 64'(err_o), 64'd1);
        send_read(32'h100, 6, 2);
        run_until_idle("read_after_drain_done", 200);
        check_eq("err_sticky", 64'(err_o), 64'd1);
`else
        check_eq("err_tied_low", 64'(err_o), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
